memory: RTL and testbench

- Main-memory model behind the cache hierarchy; serves whole cache-line reads and writes with a fixed multi-cycle access latency.
- A requester (cache controller) holds `enable` with `op`/`address`/`data_in`, waits for `data_ready`, then drops `enable`.
- Storage is a line-organised array; access is line-aligned.

---
 rtl/memory_if.sv | 39 +++
 rtl/memory.sv | 130 +++++++++++++
 tb/tb_memory.sv | 182 ++++++++++++++++++
 3 files changed

// File: rtl/memory_if.sv
// memory_if: request/response bundle between a cache controller and main memory.
//
// Handshake: the master raises `enable` with `op`/`address`/`data_in` stable
// and keeps `enable` high until it sees `data_ready`. The slave takes `op`,
// `address` and `data_in` on the edge where it accepts the request and
// ignores them after that. `data_ready` stays high while `enable` stays high.
// It drops on the first edge with `enable` low. A new request needs at least
// one cycle with `enable` low.
//
// Signals:
//   enable        master->slave  request valid
//   op            master->slave  1 = write line, 0 = read line
//   address       master->slave  byte address (low 4 bits ignored)
//   data_in       master->slave  write line data
//   memory_in_use master->slave  arbitration hint, no functional effect
//   data_out      slave->master  read line data
//   data_ready    slave->master  request complete
interface memory_if #(
    parameter int ADDR_W = 32,
    parameter int LINE_W = 128
);
    logic              enable;
    logic              op;
    logic [ADDR_W-1:0] address;
    logic [LINE_W-1:0] data_in;
    logic              memory_in_use;
    logic [LINE_W-1:0] data_out;
    logic              data_ready;

    modport master (
        output enable, op, address, data_in, memory_in_use,
        input  data_out, data_ready
    );

    modport slave (
        input  enable, op, address, data_in, memory_in_use,
        output data_out, data_ready
    );
endinterface

// File: rtl/memory.sv
// memory: line-organised main-memory model with a fixed access latency.
//
// A request is accepted in IDLE when `enable` is high. It completes exactly
// MEMORY_DELAY_CYCLES edges later. A write stores the line at completion. A
// read loads `data_out` at completion. After completion `data_ready` stays
// high until `enable` drops.
//
// Ports:
//   clk          in   system clock, rising edge
//   reset        in   synchronous active-high reset (array is not cleared)
//   bus          slave side of memory_if (request/response signals)
//   dbg_state_o  out  current FSM state (0 IDLE, 1 BUSY, 2 DONE)
module memory #(
    parameter int MEMORY_ADDRESS_SIZE = 32,
    parameter int CACHE_LINE_SIZE     = 128,
    parameter int MEMORY_DELAY_CYCLES = 5,
    parameter int MEMORY_LINES        = 256
) (
    input  logic       clk,
    input  logic       reset,
    memory_if.slave    bus,
    output logic [1:0] dbg_state_o
);
    // MEMORY_LINES is a power of two, so "modulo MEMORY_LINES" on the line
    // number is a plain bit slice above the 4 offset bits.
    localparam int IDX_W = $clog2(MEMORY_LINES);
    localparam int CNT_W = $clog2(MEMORY_DELAY_CYCLES + 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t                     state_q, state_d;
    logic [CNT_W-1:0]           counter_q, counter_d;
    logic                       op_q, op_d;
    logic [IDX_W-1:0]           idx_q, idx_d;
    logic [CACHE_LINE_SIZE-1:0] wdata_q, wdata_d;
    logic [CACHE_LINE_SIZE-1:0] data_out_q, data_out_d;
    logic                       data_ready_q, data_ready_d;
    logic                       mem_we;

    // Lines power up as zero. Reset leaves the contents alone.
    logic [CACHE_LINE_SIZE-1:0] mem_q [MEMORY_LINES] = '{default: '0};

    // The hint input and the offset and out-of-range address bits are unused.
    logic unused_ok;
    assign unused_ok = ^{bus.memory_in_use, bus.address[3:0],
                         bus.address[MEMORY_ADDRESS_SIZE-1:4+IDX_W]};

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= IDLE;
            counter_q    <= '0;
            op_q         <= 1'b0;
            idx_q        <= '0;
            wdata_q      <= '0;
            data_out_q   <= '0;
            data_ready_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            counter_q    <= counter_d;
            op_q         <= op_d;
            idx_q        <= idx_d;
            wdata_q      <= wdata_d;
            data_out_q   <= data_out_d;
            data_ready_q <= data_ready_d;
        end
    end

    always_ff @(posedge clk) begin
        if (mem_we) begin
            mem_q[idx_q] <= wdata_q;
        end
    end

    always_comb begin
        state_d      = state_q;
        counter_d    = counter_q;
        op_d         = op_q;
        idx_d        = idx_q;
        wdata_d      = wdata_q;
        data_out_d   = data_out_q;
        data_ready_d = data_ready_q;
        mem_we       = 1'b0;

        unique case (state_q)
            IDLE: begin
                data_ready_d = 1'b0;
                if (bus.enable) begin
                    op_d      = bus.op;
                    idx_d     = bus.address[4 +: IDX_W];
                    wdata_d   = bus.data_in;
                    counter_d = CNT_W'(1);
                    state_d   = BUSY;
                end
            end
            BUSY: begin
                // The counter reads 1 right after acceptance. Completion
                // happens on the edge that sees MEMORY_DELAY_CYCLES, which is
                // MEMORY_DELAY_CYCLES edges after acceptance.
                if (counter_q == CNT_W'(MEMORY_DELAY_CYCLES)) begin
                    if (op_q) begin
                        mem_we = !reset;
                    end else begin
                        data_out_d = mem_q[idx_q];
                    end
                    data_ready_d = 1'b1;
                    state_d      = DONE;
                end else begin
                    counter_d = counter_q + CNT_W'(1);
                end
            end
            DONE: begin
                if (!bus.enable) begin
                    data_ready_d = 1'b0;
                    state_d      = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign bus.data_out   = data_out_q;
    assign bus.data_ready = data_ready_q;
    assign dbg_state_o    = state_q;
endmodule

// File: tb/tb_memory.sv
// tb_memory: self-checking bench for the memory line model.
module tb_memory;
  localparam int ADDR_W  = 32;
  localparam int LINE_W  = 128;
  localparam int DELAY   = 5;
  localparam int N_LINES = 256;

  logic       clk;
  logic       reset;
  logic [1:0] dbg_state;

  memory_if #(.ADDR_W(ADDR_W), .LINE_W(LINE_W)) bus ();

  memory #(
    .MEMORY_ADDRESS_SIZE(ADDR_W),
    .CACHE_LINE_SIZE(LINE_W),
    .MEMORY_DELAY_CYCLES(DELAY),
    .MEMORY_LINES(N_LINES)
  ) dut (
    .clk(clk),
    .reset(reset),
    .bus(bus),
    .dbg_state_o(dbg_state)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- scoreboard ----------------
  logic [LINE_W-1:0] exp_q[$];
  logic [LINE_W-1:0] model_mem [N_LINES];
  logic [LINE_W-1:0] last_dout;
  int total;
  int bad;

  task automatic chk(input string tag, input logic [LINE_W-1:0] obs, input logic [LINE_W-1:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic int line_of(input logic [ADDR_W-1:0] a);
    return int'(a / 16) % N_LINES;
  endfunction

  // ---------------- driver ----------------
  // Issues one request and keeps enable high for `hold` cycles, counting the
  // accept edge. While the request is in flight, address and data are
  // scrambled to show that only the accepted values are used.
  task automatic mem_req(input logic wr, input logic [ADDR_W-1:0] addr,
                         input logic [LINE_W-1:0] wdata, input int hold);
    int lat;
    bit got;
    if (wr) model_mem[line_of(addr)] = wdata;
    else    exp_q.push_back(model_mem[line_of(addr)]);
    @(negedge clk);
    bus.enable  = 1'b1;
    bus.op      = wr;
    bus.address = addr;
    bus.data_in = wdata;
    @(posedge clk); #1;
    lat = 0;
    got = 0;
    if (hold <= 1) bus.enable = 1'b0;
    bus.address = $urandom;
    bus.data_in = {$urandom, $urandom, $urandom, $urandom};
    while (!got && lat < 20) begin
      @(posedge clk); #1;
      lat++;
      if (bus.data_ready) got = 1;
      if (lat + 1 >= hold) bus.enable = 1'b0;
    end
    chk("latency", LINE_W'(lat), LINE_W'(DELAY));
    if (!wr) begin
      last_dout = exp_q.pop_front();
      chk("read_data", bus.data_out, last_dout);
    end else begin
      chk("dout_hold_on_write", bus.data_out, last_dout);
    end
    while (bus.enable && lat + 1 < hold) begin
      @(posedge clk); #1;
      lat++;
      chk("ready_held", LINE_W'(bus.data_ready), LINE_W'(1));
      chk("state_done", LINE_W'(dbg_state), LINE_W'(2));
    end
    bus.enable = 1'b0;
    @(posedge clk); #1;
    chk("ready_drop", LINE_W'(bus.data_ready), LINE_W'(0));
    chk("state_idle", LINE_W'(dbg_state), LINE_W'(0));
  endtask

  // ---------------- stimulus ----------------
  initial begin
    logic [LINE_W-1:0] pat_a;
    logic [LINE_W-1:0] pat_b;
    logic [LINE_W-1:0] pat_c;
    total = 0;
    bad = 0;
    last_dout = '0;
    for (int i = 0; i < N_LINES; i++) model_mem[i] = '0;
    pat_a = 128'h00FF00FF00FF00FF00FF00FF00FF00FF;
    pat_b = 128'hDEADBEEF_01234567_89ABCDEF_CAFEF00D;
    pat_c = 128'h1111_2222_3333_4444_5555_6666_7777_8888;

    bus.enable  = 1'b0;
    bus.op      = 1'b0;
    bus.address = '0;
    bus.data_in = '0;
    reset = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    chk("rst_ready", LINE_W'(bus.data_ready), LINE_W'(0));
    chk("rst_dout", bus.data_out, '0);
    chk("rst_state", LINE_W'(dbg_state), LINE_W'(0));

    // 1: read of a fresh line
    mem_req(1'b0, 32'h0, '0, 2);
    // 2: write then read with enable held 7 cycles
    mem_req(1'b1, 32'h0, pat_a, 7);
    mem_req(1'b0, 32'h0, '0, 7);
    // 3: low nibble ignored; neighbour line unaffected
    mem_req(1'b1, 32'h10, pat_b, 6);
    mem_req(1'b0, 32'h1C, '0, 6);
    mem_req(1'b0, 32'h0, '0, 6);
    // 4: enable dropped early; the request still completes
    mem_req(1'b0, 32'h10, '0, 2);
    mem_req(1'b1, 32'h50, pat_c, 2);
    mem_req(1'b0, 32'h5F, '0, 2);

    // 5: reset during the BUSY phase of a write aborts it
    mem_req(1'b1, 32'h20, pat_c, 6);
    @(negedge clk);
    bus.enable  = 1'b1;
    bus.op      = 1'b1;
    bus.address = 32'h20;
    bus.data_in = pat_a;
    @(posedge clk);
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b1;
    bus.enable = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    chk("abort_ready", LINE_W'(bus.data_ready), LINE_W'(0));
    chk("abort_dout", bus.data_out, '0);
    chk("abort_state", LINE_W'(dbg_state), LINE_W'(0));
    @(negedge clk);
    reset = 1'b0;
    last_dout = '0;
    mem_req(1'b0, 32'h20, '0, 2);

    // 6: address wrap aliases line 0
    mem_req(1'b1, 32'h1000, pat_b, 2);
    mem_req(1'b0, 32'h0, '0, 2);
    mem_req(1'b0, 32'hFFFF_F00C, '0, 3);

    // random mix across a few wraps of the array
    for (int i = 0; i < 24; i++) begin
      logic [ADDR_W-1:0] a;
      a = ADDR_W'($urandom_range(0, 32'h2FFF));
      if ($urandom_range(0, 1) == 1)
        mem_req(1'b1, a, {$urandom, $urandom, $urandom, $urandom}, $urandom_range(1, 8));
      else
        mem_req(1'b0, a, '0, $urandom_range(1, 8));
    end

    chk("queue_empty", LINE_W'(exp_q.size()), LINE_W'(0));
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  // Overall watchdog so the run always ends.
  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end
endmodule
